// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract engine: one full-adder/subtractor slice reused over WIDTH cycles, LSB first.
// Optional signed-overflow flag port `ovf` is enabled by defining OVERFLOW_FLAG_EN.
module serial_add_sub #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_cb;
    logic               r_op;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_s;
    logic               w_cb_next;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;
`ifdef OVERFLOW_FLAG_EN
    logic               w_ovf;
`endif

    // Single slice: the carry term for add becomes the borrow term for subtract.
    assign w_a_bit    = r_a_sh[0];
    assign w_b_bit    = r_b_sh[0];
    assign w_s        = w_a_bit ^ w_b_bit ^ r_cb;
    assign w_cb_next  = r_op ? ((~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_cb))
                             : ((w_a_bit & w_b_bit) | ((w_a_bit ^ w_b_bit) & r_cb));
    assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
    assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef OVERFLOW_FLAG_EN
    // On the last bit the shifters hold the operand sign bits.
    assign w_ovf = r_op ? ((w_a_bit != w_b_bit) && (w_s != w_a_bit))
                        : ((w_a_bit == w_b_bit) && (w_s != w_a_bit));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_cb      <= 1'b0;
            r_op      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_cb    <= c_in;
                        r_op    <= sel;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_acc  <= w_acc_next;
                    r_cb   <= w_cb_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Outputs update only here, so they never expose partial results.
                    if (w_last) begin
                        result    <= w_acc_next;
                        carry_out <= w_cb_next;
`ifdef OVERFLOW_FLAG_EN
                        ovf       <= w_ovf;
`endif
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH=8): vector table, scoreboard queue, hand-written corner sequences.
// Define OVERFLOW_FLAG_EN to also exercise the ovf port.
module tb_serial_add_sub;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } exp_t;

    typedef struct packed {
        logic         sel;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] res;
        logic         co;
        logic         ov;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sel = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    serial_add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sel       (sel),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
`ifdef OVERFLOW_FLAG_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, independent of the bit-serial structure.
    function automatic exp_t model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        exp_t       e;
        logic [W:0] t;
        int         sr;
        if (!s) begin
            t  = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
            sr = int'($signed(x)) + int'($signed(y)) + int'(ci);
        end else begin
            t  = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
            sr = int'($signed(x)) - int'($signed(y)) - int'(ci);
        end
        e.res = t[W-1:0];
        e.co  = t[W];
        e.ov  = (sr > 127) || (sr < -128);
        return e;
    endfunction

    // Scoreboard: every done pulse must match the oldest pending expectation.
    always @(posedge clk) begin
        #1;
        if (rst_n && done) begin
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", 32'(result), 32'(e.res));
                check("carry_out", 32'(carry_out), 32'(e.co));
`ifdef OVERFLOW_FLAG_EN
                check("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    task automatic wait_done(input string name, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!done && cyc < 40);
        if (!done) check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    task automatic drive_start(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic ci);
        @(negedge clk);
        start = 1'b1; sel = s; a = x; b = y; c_in = ci;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input exp_t e);
        int cyc;
        q.push_back(e);
        drive_start(s, x, y, ci);
        wait_done("run_op", cyc);
    endtask

    vec_t vecs[8];

    initial begin
        int   cyc;
        int   cyc2;
        int   ndone;
        exp_t e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rs;
        logic rc;

        vecs[0] = '{1'b0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 8'h10, 8'h01, 1'b1, 8'h0E, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 8'h10, 8'h10, 1'b0, 8'h20, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_carry", 32'(carry_out), 32'd0);
`ifdef OVERFLOW_FLAG_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: busy after E0 through E7, done only after E8
        q.push_back(model(1'b0, 8'h3C, 8'h05, 1'b0));
        drive_start(1'b0, 8'h3C, 8'h05, 1'b0);
        for (int k = 0; k < 8; k++) begin
            check("lat_busy", 32'(busy), 32'd1);
            check("lat_done_low", 32'(done), 32'd0);
            check("lat_result_held", 32'(result), 32'd0);
            a = 8'hFF; b = 8'hFF; sel = 1'b1; c_in = 1'b1;
            @(posedge clk);
            #1;
        end
        check("lat_done_high", 32'(done), 32'd1);
        check("lat_busy_low", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(done), 32'd0);

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            e.res = vecs[i].res; e.co = vecs[i].co; e.ov = vecs[i].ov;
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, e);
        end

        // Random operations against the arithmetic model
        for (int i = 0; i < 12; i++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            run_op(rs, ra, rb, rc, model(rs, ra, rb, rc));
        end

        // start while busy is ignored; start in the done cycle is accepted
        q.push_back(model(1'b0, 8'h3C, 8'h05, 1'b0));
        drive_start(1'b0, 8'h3C, 8'h05, 1'b0);
        repeat (2) @(posedge clk);
        drive_start(1'b1, 8'hAA, 8'h11, 1'b1);
        wait_done("ign", cyc);
        q.push_back(model(1'b1, 8'h90, 8'h21, 1'b0));
        start = 1'b1; sel = 1'b1; a = 8'h90; b = 8'h21; c_in = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done("b2b", cyc2);
        check("b2b_gap", 32'(cyc2 + 1), 32'd9);

        // Reset mid-RUN aborts with outputs cleared and no done afterwards
        drive_start(1'b0, 8'h12, 8'h34, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_carry", 32'(carry_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        // One more operation after the abort to show recovery
        run_op(1'b0, 8'hC8, 8'h64, 1'b1, model(1'b0, 8'hC8, 8'h64, 1'b1));

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
